// File: rtl/vga_pkg.sv
// Shared timing descriptors, pipeline side-band bundle and colour conversion
// for the VGA scan engine.
package vga_pkg;

  typedef struct packed {
    logic [10:0] h_res;
    logic [10:0] h_fp;
    logic [10:0] h_sync;
    logic [10:0] h_bp;
    logic [10:0] v_res;
    logic [10:0] v_fp;
    logic [10:0] v_sync;
    logic [10:0] v_bp;
    logic        pol;
  } mode_t;

  // Index 0: 640x480@60 negative syncs, index 1: 800x600@60 positive syncs
  localparam mode_t MODE_TABLE [2] = '{
    '{h_res: 11'd640, h_fp: 11'd16, h_sync: 11'd96,  h_bp: 11'd48,
      v_res: 11'd480, v_fp: 11'd10, v_sync: 11'd2,   v_bp: 11'd33, pol: 1'b0},
    '{h_res: 11'd800, h_fp: 11'd40, h_sync: 11'd128, h_bp: 11'd88,
      v_res: 11'd600, v_fp: 11'd1,  v_sync: 11'd4,   v_bp: 11'd23, pol: 1'b1}
  };

  typedef struct packed {
    logic mode;
    logic frame;
    logic in_fb;
    logic de;
    logic vs;
    logic hs;
  } side_t;

  localparam side_t SIDE_IDLE = '{mode: 1'b0, frame: 1'b0, in_fb: 1'b0,
                                  de: 1'b0, vs: 1'b1, hs: 1'b1};

  function automatic logic [10:0] h_total(input mode_t m);
    return m.h_res + m.h_fp + m.h_sync + m.h_bp;
  endfunction

  function automatic logic [10:0] v_total(input mode_t m);
    return m.v_res + m.v_fp + m.v_sync + m.v_bp;
  endfunction

  function automatic logic [11:0] rgb565_to_444(input logic [15:0] d);
    return {d[15:12], d[10:7], d[4:1]};
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline with a configurable reset value, used to line
// the sync/DE side-band up with framebuffer read data.
module vga_delay_line #(
  parameter int unsigned  W       = 1,
  parameter int unsigned  DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= RST_VAL;
    end else begin
      pipe_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_engine.sv
// Two-mode VGA timing generator with integer-upscaled framebuffer fetch and
// RGB565->444 output, all pins aligned at RD_LAT+1 cycles after the counters.
module vga_scan_engine
  import vga_pkg::*;
#(
  parameter int unsigned FB_W       = 160,
  parameter int unsigned FB_H       = 120,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned RD_LAT     = 1,
  parameter logic [11:0] BORDER_RGB = 12'h000,
  parameter mode_t       MODE0_T    = MODE_TABLE[0],
  parameter mode_t       MODE1_T    = MODE_TABLE[1]
) (
  input  logic              i_pix_clk,
  input  logic              i_rst,
  input  logic              i_mode,
  input  logic [15:0]       i_fb_data,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_de,
  output logic [3:0]        o_r,
  output logic [3:0]        o_g,
  output logic [3:0]        o_b,
  output logic              o_frame,
  output logic              o_mode
);

  localparam int unsigned WIN_W    = FB_W << SCALE_LOG2;
  localparam int unsigned WIN_H    = FB_H << SCALE_LOG2;
  localparam int unsigned ROW_MASK = (1 << SCALE_LOG2) - 1;

  logic [10:0]       hc_q, hc_d, vc_q, vc_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
  mode_t             cur, nxt;
  side_t             side_raw, side0_q, side_al, out_q;
  logic [11:0]       rgb_q, rgb_d;

  function automatic mode_t sel(input logic m);
    return m ? MODE1_T : MODE0_T;
  endfunction

  function automatic logic in_win(input logic [10:0] h, input logic [10:0] v,
                                  input mode_t g);
    return (h < g.h_res) && (v < g.v_res) && (32'(h) < WIN_W) && (32'(v) < WIN_H);
  endfunction

  function automatic logic in_band(input logic [10:0] c, input logic [10:0] start,
                                   input logic [10:0] len);
    return (c >= start) && (c < start + len);
  endfunction

  // The address register is loaded from next-state counters so o_fb_addr
  // matches the live counter position; this buys back the cycle that lets
  // registered pins sit exactly RD_LAT+1 behind the counters.
  always_comb begin
    cur        = sel(mode_q);
    hc_d       = hc_q + 11'd1;
    vc_d       = vc_q;
    mode_d     = mode_q;
    row_base_d = row_base_q;
    if (hc_q == h_total(cur) - 11'd1) begin
      hc_d = '0;
      if (vc_q == v_total(cur) - 11'd1) begin
        vc_d       = '0;
        mode_d     = i_mode;
        row_base_d = '0;
      end else begin
        vc_d = vc_q + 11'd1;
        if ((vc_q < cur.v_res) && (32'(vc_q) + 1 < WIN_H) &&
            ((32'(vc_q) & ROW_MASK) == ROW_MASK))
          row_base_d = row_base_q + ADDR_W'(FB_W);
      end
    end

    nxt    = sel(mode_d);
    addr_d = addr_q;
    if (in_win(hc_d, vc_d, nxt))
      addr_d = row_base_d + ADDR_W'(32'(hc_d) >> SCALE_LOG2);

    side_raw.hs    = in_band(hc_q, cur.h_res + cur.h_fp, cur.h_sync) ? cur.pol : ~cur.pol;
    side_raw.vs    = in_band(vc_q, cur.v_res + cur.v_fp, cur.v_sync) ? cur.pol : ~cur.pol;
    side_raw.de    = (hc_q < cur.h_res) && (vc_q < cur.v_res);
    side_raw.in_fb = in_win(hc_q, vc_q, cur);
    side_raw.frame = (hc_q == '0) && (vc_q == '0);
    side_raw.mode  = mode_q;
  end

  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      hc_q       <= '0;
      vc_q       <= '0;
      mode_q     <= 1'b0;
      row_base_q <= '0;
      addr_q     <= '0;
      side0_q    <= SIDE_IDLE;
    end else begin
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      mode_q     <= mode_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      side0_q    <= side_raw;
    end
  end

  // Side-band needs RD_LAT-1 more stages to meet i_fb_data; the output
  // register below is the last of the RD_LAT stages after stage 0.
  if (RD_LAT > 1) begin : g_align
    vga_delay_line #(
      .W      ($bits(side_t)),
      .DEPTH  (RD_LAT - 1),
      .RST_VAL(SIDE_IDLE)
    ) u_align (
      .clk_i(i_pix_clk),
      .rst_i(i_rst),
      .d_i  (side0_q),
      .q_o  (side_al)
    );
  end else begin : g_noalign
    assign side_al = side0_q;
  end

  always_comb begin
    rgb_d = '0;
    if (side_al.de) rgb_d = side_al.in_fb ? rgb565_to_444(i_fb_data) : BORDER_RGB;
  end

  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q <= SIDE_IDLE;
      rgb_q <= '0;
    end else begin
      out_q <= side_al;
      rgb_q <= rgb_d;
    end
  end

  assign o_fb_addr       = addr_q;
  assign o_hs            = out_q.hs;
  assign o_vs            = out_q.vs;
  assign o_de            = out_q.de;
  assign o_frame         = out_q.frame;
  assign o_mode          = out_q.mode;
  assign {o_r, o_g, o_b} = rgb_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Scoreboard bench: four engine instances (reduced geometry at RD_LAT 1..3,
// standard geometry at RD_LAT 1) share clock, reset and mode stimulus.
module tb_vga_scan_engine;
  import vga_pkg::*;

  typedef struct packed {
    logic hs, vs, de, frame, mode;
    logic [11:0] rgb;
  } exp_t;

  localparam exp_t IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, frame: 1'b0, mode: 1'b0, rgb: 12'h000};
  localparam logic [11:0] BORDER = 12'h0F0;
  localparam mode_t SMALL0 = '{h_res: 11'd24, h_fp: 11'd3, h_sync: 11'd5, h_bp: 11'd4,
                               v_res: 11'd12, v_fp: 11'd2, v_sync: 11'd2, v_bp: 11'd3, pol: 1'b0};
  localparam mode_t SMALL1 = '{h_res: 11'd40, h_fp: 11'd2, h_sync: 11'd6, h_bp: 11'd4,
                               v_res: 11'd20, v_fp: 11'd1, v_sync: 11'd3, v_bp: 11'd2, pol: 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode_in = 1'b0;
  logic [15:0] fbmem [19200];
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  for (genvar L = 0; L < 4; L++) begin : lanes
    localparam bit          BIG  = (L == 3);
    localparam int unsigned RDL  = BIG ? 1 : L + 1;
    localparam int unsigned FBW  = BIG ? 160 : 8;
    localparam int unsigned FBH  = BIG ? 120 : 4;
    localparam int unsigned AW   = BIG ? 15 : 6;
    localparam int unsigned MAXA = FBW * FBH - 1;
    localparam mode_t       G0   = BIG ? MODE_TABLE[0] : SMALL0;
    localparam mode_t       G1   = BIG ? MODE_TABLE[1] : SMALL1;

    logic [AW-1:0] addr;
    logic [15:0]   fbd;
    logic          hs, vs, de, fr, md;
    logic [3:0]    r, g, b;
    logic [15:0]   rd_pipe [RDL];
    exp_t          q[$];
    int unsigned   mx, my;
    logic          mm;

    vga_scan_engine #(
      .FB_W      (FBW),
      .FB_H      (FBH),
      .SCALE_LOG2(2),
      .ADDR_W    (AW),
      .RD_LAT    (RDL),
      .BORDER_RGB(BORDER),
      .MODE0_T   (G0),
      .MODE1_T   (G1)
    ) dut (
      .i_pix_clk(clk),
      .i_rst    (rst),
      .i_mode   (mode_in),
      .i_fb_data(fbd),
      .o_fb_addr(addr),
      .o_hs     (hs),
      .o_vs     (vs),
      .o_de     (de),
      .o_r      (r),
      .o_g      (g),
      .o_b      (b),
      .o_frame  (fr),
      .o_mode   (md)
    );

    // Framebuffer BRAM: data for an address appears RDL cycles later.
    always @(posedge clk) begin
      rd_pipe[0] <= fbmem[addr];
      for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign fbd = rd_pipe[RDL-1];

    function automatic exp_t pixel(input int unsigned x, input int unsigned y, input logic m);
      mode_t       gm;
      exp_t        e;
      int unsigned a, hs0, vs0;
      gm    = m ? G1 : G0;
      hs0   = gm.h_res + gm.h_fp;
      vs0   = gm.v_res + gm.v_fp;
      e.mode  = m;
      e.frame = (x == 0) && (y == 0);
      e.de    = (x < gm.h_res) && (y < gm.v_res);
      e.hs    = (x >= hs0 && x < hs0 + gm.h_sync) ? gm.pol : ~gm.pol;
      e.vs    = (y >= vs0 && y < vs0 + gm.v_sync) ? gm.pol : ~gm.pol;
      e.rgb   = 12'h000;
      if (e.de) begin
        if (x < FBW * 4 && y < FBH * 4) begin
          a     = (y / 4) * FBW + x / 4;
          e.rgb = {fbmem[a][15:12], fbmem[a][10:7], fbmem[a][4:1]};
        end else begin
          e.rgb = BORDER;
        end
      end
      return e;
    endfunction

    // Reference raster: one expected pixel per clock, RDL idle entries stand
    // in for pipeline contents right after reset.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        for (int i = 0; i < RDL; i++) q.push_back(IDLE);
        mx <= 0;
        my <= 0;
        mm <= 1'b0;
      end else begin
        mode_t gc;
        gc = mm ? G1 : G0;
        q.push_back(pixel(mx, my, mm));
        if (mx == gc.h_res + gc.h_fp + gc.h_sync + gc.h_bp - 1) begin
          mx <= 0;
          if (my == gc.v_res + gc.v_fp + gc.v_sync + gc.v_bp - 1) begin
            my <= 0;
            mm <= mode_in;
          end else begin
            my <= my + 1;
          end
        end else begin
          mx <= mx + 1;
        end
      end
    end

    always @(negedge clk) begin
      exp_t act, e;
      act = {hs, vs, de, fr, md, r, g, b};
      tests++;
      if (rst) begin
        if (act !== IDLE || addr !== '0) begin
          failed++;
          $display("FAIL lane%0d reset_state: got %h addr=%0d, want %h addr=0", L, act, addr, IDLE);
        end
      end else if (q.size() == 0) begin
        failed++;
        $display("FAIL lane%0d scoreboard_empty: got %h, want an expected entry", L, act);
      end else begin
        e = q.pop_front();
        if (act !== e || int'(addr) > MAXA) begin
          failed++;
          $display("FAIL lane%0d pixel: got hs=%b vs=%b de=%b fr=%b md=%b rgb=%h addr=%0d, want hs=%b vs=%b de=%b fr=%b md=%b rgb=%h addr<=%0d",
                   L, act.hs, act.vs, act.de, act.frame, act.mode, act.rgb, addr,
                   e.hs, e.vs, e.de, e.frame, e.mode, e.rgb, MAXA);
        end
      end
    end
  end

  task automatic wait_line(input int unsigned y);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(lanes[0].my == y && lanes[0].mx == 0) && n < 5000);
    if (n >= 5000) begin
      tests++;
      failed++;
      $display("FAIL wait_line: got no line %0d start in %0d cycles, want one", y, n);
    end
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) fbmem[i] = 16'($urandom);
    fbmem[0]     = 16'hF800;
    fbmem[21]    = 16'hF800;
    fbmem[31]    = 16'hF800;
    fbmem[160]   = 16'hF800;
    fbmem[19199] = 16'hF800;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (4900) @(negedge clk);

    for (int ep = 0; ep < 12; ep++) begin
      case (ep % 3)
        0: begin
          // Mid-frame excursion that returns before the frame boundary.
          wait_line(1);
          #1 mode_in = ~mode_in;
          repeat ($urandom_range(150, 1)) @(negedge clk);
          #1 mode_in = ~mode_in;
          wait_line(0);
          wait_line(2);
        end
        1: begin
          wait_line(2);
          #1 mode_in = ~mode_in;
          wait_line(0);
          wait_line(3);
          wait_line(0);
        end
        default: begin
          wait_line($urandom_range(10, 3));
          repeat ($urandom_range(20, 0)) @(negedge clk);
          #1 rst = 1'b1;
          repeat ($urandom_range(4, 1)) @(negedge clk);
          #1 rst = 1'b0;
          repeat (300) @(negedge clk);
        end
      endcase
    end

    repeat (200) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
